// File: rtl/gcd_pkg.sv
// rtl/gcd_pkg.sv - shared constants and FSM state type for the GCD scheduler
package gcd_pkg;

    localparam int DEF_WIDTH = 64;
    localparam int DEF_NREQ  = 4;
    localparam int DEF_CW    = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/euclidean_gcd.sv
// rtl/euclidean_gcd.sv - subtractive Euclid engine with start/done pulses
module euclidean_gcd #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    logic             running;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;

    // One subtract-or-swap step per cycle; finishes when y reaches zero, so
    // b=0 returns a directly and a=0 swaps b into x before finishing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            running <= 1'b0;
            done    <= 1'b0;
            x       <= '0;
            y       <= '0;
            result  <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                x       <= a;
                y       <= b;
                running <= 1'b1;
            end else if (running) begin
                if (y == '0) begin
                    result  <= x;
                    done    <= 1'b1;
                    running <= 1'b0;
                end else if (x < y) begin
                    x <= y;
                    y <= x;
                end else begin
                    x <= x - y;
                end
            end
        end
    end

endmodule

// File: rtl/gcd_rr_scheduler.sv
// rtl/gcd_rr_scheduler.sv - round-robin front end sharing one GCD engine
module gcd_rr_scheduler
    import gcd_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREQ  = DEF_NREQ,
    parameter int CW    = DEF_CW,
    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic                  rsp_valid,
    output logic [IW-1:0]         rsp_id,
    output logic [WIDTH-1:0]      rsp_result,
    output logic [CW-1:0]         rsp_cycles,
    output logic                  busy
);

    state_t           state;
    state_t           state_nxt;
    logic [IW-1:0]    rr_ptr;
    logic [IW-1:0]    grant_id;
    logic             grant_any;
    logic             handshake;
    logic [IW-1:0]    job_id;
    logic [WIDTH-1:0] job_a;
    logic [WIDTH-1:0] job_b;
    logic [CW-1:0]    cnt;
    logic             eng_start;
    logic             eng_done;
    logic [WIDTH-1:0] eng_result;
    int               idx;

    // Round-robin winner: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        idx       = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (req_valid[idx]) begin
                grant_any = 1'b1;
                grant_id  = idx[IW-1:0];
            end
        end
    end

    // Only the winner sees ready, and only while the engine is free.
    always_comb begin
        req_ready = '0;
        if (state == S_IDLE && grant_any) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    assign handshake = (state == S_IDLE) && grant_any;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (handshake) state_nxt = S_START;
            S_START: state_nxt = S_WAIT;
            S_WAIT:  if (eng_done) state_nxt = S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        busy      = (state != S_IDLE);
        rsp_valid = (state == S_RESP);
        eng_start = (state == S_START);
    end

    // Job capture, pointer rotation, latency counting and response holding.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr     <= '0;
            job_id     <= '0;
            job_a      <= '0;
            job_b      <= '0;
            cnt        <= '0;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_cycles <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (handshake) begin
                        job_id <= grant_id;
                        job_a  <= req_a[int'(grant_id)*WIDTH +: WIDTH];
                        job_b  <= req_b[int'(grant_id)*WIDTH +: WIDTH];
                        rr_ptr <= (grant_id == IW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
                    end
                end
                S_START: begin
                    cnt <= {{(CW-1){1'b0}}, 1'b1};
                end
                S_WAIT: begin
                    if (cnt != {CW{1'b1}}) begin
                        cnt <= cnt + 1'b1;
                    end
                    if (eng_done) begin
                        rsp_id     <= job_id;
                        rsp_result <= eng_result;
                        rsp_cycles <= cnt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    euclidean_gcd #(
        .WIDTH (WIDTH)
    ) u_gcd (
        .clk    (clk),
        .rst    (rst),
        .start  (eng_start),
        .a      (job_a),
        .b      (job_b),
        .done   (eng_done),
        .result (eng_result)
    );

endmodule

// File: tb/tb_gcd_rr_scheduler.sv
// tb/tb_gcd_rr_scheduler.sv - randomized scoreboard bench for gcd_rr_scheduler
module tb_gcd_rr_scheduler;

    localparam int WIDTH = 64;
    localparam int NREQ  = 4;
    localparam int CW    = 16;
    localparam int IW    = 2;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } job_t;

    typedef struct packed {
        logic [IW-1:0]    id;
        logic [WIDTH-1:0] res;
    } exp_t;

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic [IW-1:0]         rsp_id;
    logic [WIDTH-1:0]      rsp_result;
    logic [CW-1:0]         rsp_cycles;
    logic                  busy;

    job_t agent_q [NREQ][$];
    job_t model_q [NREQ][$];
    exp_t sb [$];
    int   lat_q [$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   m_ptr   = 0;
    int   cyc     = 0;

    gcd_rr_scheduler #(
        .WIDTH (WIDTH),
        .NREQ  (NREQ),
        .CW    (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_cycles (rsp_cycles),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [WIDTH-1:0] ref_gcd(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] x = a;
        logic [WIDTH-1:0] y = b;
        logic [WIDTH-1:0] t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic add_job(input int id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        job_t j;
        j.a = a;
        j.b = b;
        agent_q[id].push_back(j);
        model_q[id].push_back(j);
    endtask

    function automatic bit model_pending();
        for (int i = 0; i < NREQ; i++) if (model_q[i].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit agent_pending();
        for (int i = 0; i < NREQ; i++) if (agent_q[i].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    // Reference order: every requester with work keeps asking, so each job goes
    // to the first non-empty requester at or after the rotating pointer.
    task automatic run_batch(input string name);
        int   w;
        int   t;
        job_t j;
        exp_t e;
        while (model_pending()) begin
            w = -1;
            for (int k = 0; k < NREQ && w < 0; k++) begin
                if (model_q[(m_ptr + k) % NREQ].size() != 0) w = (m_ptr + k) % NREQ;
            end
            j = model_q[w].pop_front();
            e.id  = IW'(w);
            e.res = ref_gcd(j.a, j.b);
            sb.push_back(e);
            m_ptr = (w + 1) % NREQ;
        end
        t = 0;
        @(posedge clk);
        while ((sb.size() != 0 || busy || agent_pending()) && t < 20000) begin
            @(posedge clk);
            t++;
        end
        if (t >= 20000) begin
            n_total++;
            $display("FAIL %s_timeout: %0d responses outstanding, expected 0", name, sb.size());
            sb.delete();
        end
        repeat (2) @(posedge clk);
    endtask

    // Requester agents: hold the head job valid until granted, then present the next.
    initial begin : agents
        logic [NREQ-1:0] hs;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        forever begin
            @(negedge clk);
            hs = rst ? '0 : (req_valid & req_ready);
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (hs[i] && agent_q[i].size() != 0) void'(agent_q[i].pop_front());
                if (agent_q[i].size() != 0) begin
                    req_valid[i]              = 1'b1;
                    req_a[i*WIDTH +: WIDTH]   = agent_q[i][0].a;
                    req_b[i*WIDTH +: WIDTH]   = agent_q[i][0].b;
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
        end
    end

    // Monitor: measures engine latency, checks each response against the scoreboard.
    initial begin : monitor
        int   start_cyc = 0;
        int   l;
        bit   chk_busy = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                lat_q.delete();
                chk_busy = 1'b0;
            end else begin
                if (chk_busy) begin
                    check("busy_after_rsp", WIDTH'(busy), 0);
                    chk_busy = 1'b0;
                end
                if (dut.u_gcd.start) start_cyc = cyc;
                if (dut.u_gcd.done) lat_q.push_back(cyc - start_cyc);
                if (rsp_valid) begin
                    chk_busy = 1'b1;
                    if (sb.size() == 0) begin
                        n_total++;
                        $display("FAIL unexpected_rsp: rsp_valid=1 id=%0d, expected no response", rsp_id);
                    end else begin
                        e = sb.pop_front();
                        check("rsp_id", WIDTH'(rsp_id), WIDTH'(e.id));
                        check("rsp_result", rsp_result, e.res);
                        if (lat_q.size() == 0) begin
                            n_total++;
                            $display("FAIL rsp_cycles: got %0d, expected a measured engine latency", rsp_cycles);
                        end else begin
                            l = lat_q.pop_front();
                            check("rsp_cycles", WIDTH'(rsp_cycles), WIDTH'(l));
                            check("lat_below_sat", WIDTH'(l < (2**CW - 1)), 1);
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("%0d/%0d checks passed", n_pass, n_total + 1);
        $finish;
    end

    initial begin : main
        int t;
        logic [WIDTH-1:0] big;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rsp_valid", WIDTH'(rsp_valid), 0);
        check("reset_busy", WIDTH'(busy), 0);
        check("reset_rsp_id", WIDTH'(rsp_id), 0);
        check("reset_rsp_result", rsp_result, 0);
        check("reset_rsp_cycles", WIDTH'(rsp_cycles), 0);
        check("reset_req_ready", WIDTH'(req_ready), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        add_job(0, 48, 18);
        run_batch("single");

        add_job(1, 7, 0);
        run_batch("b_zero");
        add_job(1, 0, 0);
        run_batch("both_zero");
        add_job(3, 0, 5);
        run_batch("a_zero");

        add_job(0, 12, 8);
        add_job(1, 9, 6);
        add_job(2, 35, 21);
        add_job(3, 17, 5);
        run_batch("all_four");
        check("rr_ptr_wrap", WIDTH'(dut.rr_ptr), WIDTH'(m_ptr));

        for (int k = 0; k < 3; k++) add_job(0, 30 + k, 12);
        add_job(2, 100, 75);
        add_job(2, 64, 48);
        run_batch("fairness");

        add_job(1, 21, 13);
        run_batch("latency");

        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(0, 1) == 1) begin
                    for (int n = 0; n < int'($urandom_range(1, 3)); n++) begin
                        add_job(i, ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 200),
                                   ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 200));
                    end
                end
            end
            run_batch("random");
        end

        big = 64'h8000_0000_0000_0000;
        begin
            job_t j;
            j.a = big;
            j.b = 3;
            agent_q[1].push_back(j);
        end
        t = 0;
        while (!busy && t < 100) begin
            @(posedge clk);
            t++;
        end
        check("reset_job_started", WIDTH'(busy), 1);
        repeat (20) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check("midjob_reset_busy", WIDTH'(busy), 0);
        check("midjob_reset_rsp_valid", WIDTH'(rsp_valid), 0);
        agent_q[1].delete();
        m_ptr = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);

        add_job(2, 10, 4);
        run_batch("after_reset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/gcd_rr_scheduler.md
GCD_RR_SCHEDULER -- requirements
Module: gcd_rr_scheduler

Interface
REQ-001 Parameter WIDTH, default 64, SHALL set the operand and result width in bits.
REQ-002 Parameter NREQ, default 4, SHALL set the number of requester ports; legal range 2..8.
REQ-003 Parameter CW, default 16, SHALL set the width of the per-job cycle counter.
REQ-004 clk  input  1  SHALL be the clock; all state updates occur on its rising edge.
REQ-005 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-006 req_valid  input  NREQ  SHALL flag a pending GCD request, one bit per requester.
REQ-007 req_a  input  NREQ*WIDTH  SHALL carry operand A per requester; slice i belongs to requester i.
REQ-008 req_b  input  NREQ*WIDTH  SHALL carry operand B per requester, packed the same way as req_a.
REQ-009 req_ready  output  NREQ  SHALL be one-hot or zero and mark acceptance of the granted request.
REQ-010 rsp_valid  output  1  SHALL be a one-cycle pulse marking a completed job.
REQ-011 rsp_id  output  $clog2(NREQ)  SHALL give the requester index of the completed job.
REQ-012 rsp_result  output  WIDTH  SHALL give gcd(A,B) of the completed job.
REQ-013 rsp_cycles  output  CW  SHALL give the engine latency of the completed job.
REQ-014 busy  output  1  SHALL be high in every state except IDLE.

Function
REQ-015 FSM states SHALL be IDLE, START, WAIT, RESP.
REQ-016 In IDLE with any req_valid high, req_ready SHALL be high combinationally for the round-robin winner only: the first set bit at or after rr_ptr, wrapping at NREQ-1 to 0.
REQ-017 On handshake (req_valid[i] & req_ready[i]), the block SHALL latch req_a[i], req_b[i] and i, set rr_ptr to (i+1) mod NREQ, and enter START.
REQ-018 In START, the block SHALL pulse the engine start for exactly one cycle with the latched operands, clear the cycle counter to 1, and enter WAIT.
REQ-019 In WAIT, the counter SHALL increment each cycle and saturate at 2^CW-1; on engine done, the block SHALL latch the engine result and enter RESP.
REQ-020 In RESP, rsp_valid SHALL be 1 with rsp_id, rsp_result and rsp_cycles valid; the next state SHALL be IDLE.
REQ-021 rsp_id, rsp_result and rsp_cycles SHALL hold their values until the next RESP.
REQ-022 req_ready SHALL be 0 in START, WAIT and RESP; a new request is accepted no earlier than the cycle after RESP.
REQ-023 A requester SHALL hold req_valid and its operands stable until ready; deasserting before the grant withdraws the request with no effect.
REQ-024 Boundary: B=0 yields A; A=0, B=0 yields 0; A=0, B≠0 yields B.
REQ-025 Simultaneous requests SHALL be served strictly in rotating order; no requester waits more than NREQ-1 jobs.
REQ-026 There is no response backpressure; the requester SHALL sample rsp_* when rsp_valid=1 and rsp_id matches.

Reset
REQ-027 rst SHALL force state=IDLE, rr_ptr=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_cycles=0 and busy=0.
REQ-028 rst SHALL also reset the engine; a job in flight SHALL be discarded with no rsp_valid.
REQ-029 After rst deasserts, the first grant SHALL go to the lowest-index valid requester.

Structure
REQ-030 A shared package gcd_pkg SHALL hold the FSM state enum and the default WIDTH/NREQ/CW constants.
REQ-031 The block SHALL instantiate exactly one euclidean_gcd (start/done pulse engine) as its sole sub-module, clocked by clk and reset by rst.
REQ-032 The round-robin winner logic SHALL be combinational within gcd_rr_scheduler.

Verification
REQ-033 Single request, req0 with (48,18) -> rsp_valid pulse with rsp_id=0, rsp_result=6; busy low the cycle after the pulse.
REQ-034 Zero operand, req1 with (7,0) -> rsp_result=7; then (0,0) -> rsp_result=0.
REQ-035 All four requesters valid in the same cycle with (12,8), (9,6), (35,21), (17,5) -> responses in id order 0,1,2,3 with results 4, 3, 7, 1; rr_ptr returns to 0.
REQ-036 Fairness, req0 re-requesting continuously while req2 is pending -> grants alternate 0,2,0,2; req2 is never skipped.
REQ-037 Reset in WAIT during job (2^63, 3) -> no rsp_valid, busy=0; the next request (10,4) returns 2.
REQ-038 Latency, (21,13) -> rsp_cycles equals the cycle count measured by the bench from engine start through done, and is less than 2^CW-1.
